// File: rtl/kalkulator_param.sv
// Keypad calculator controller: builds multi-digit unsigned operands, computes + - * /
// at WIDTH bits and echoes keys and the signed result to an LCD writer as ASCII.
module kalkulator_param #(
   parameter int WIDTH      = 16,
   parameter int DIGITS     = 4,
   parameter int BCD_DIGITS = 5
) (
   input  logic                      clk,
   input  logic                      res,
   input  logic [15:0]               keys,
   input  logic                      lcd_ready,
   output logic [7:0]                data_lcd,
   output logic                      send_lcd,
   output logic [WIDTH-1:0]          data_to_bcd,
   output logic                      start_bcd,
   input  logic                      bcd_done,
   input  logic [4*BCD_DIGITS-1:0]   data_bcd,
   output logic                      error,
   output logic                      busy
);

   localparam int CW = $clog2(DIGITS + 1);
   localparam int DW = $clog2(BCD_DIGITS + 1);
   localparam logic [2*WIDTH-1:0] MAXV = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};

   typedef enum logic [3:0] {
      IDLE, WAIT_REL, DIGIT, OPER, EQ_ECHO, CALC, BCD_START, BCD_WAIT,
      SIGN, OUT_DIG, CLR_SEQ, LCD_TX, LCD_GAP
   } state_t;

   state_t state, state_n, ret, ret_n;
   logic [15:0] keys_prev;
   logic [3:0]  key, key_n, key_low, oper, oper_n, cur_dig;
   logic [WIDTH-1:0] op_a, op_a_n, op_b, op_b_n, res_mag, res_mag_n, tgt, to_bcd_n;
   logic [CW-1:0] a_cnt, a_cnt_n, b_cnt, b_cnt_n, tgt_cnt;
   logic [DW-1:0] dig_cnt, dig_cnt_n;
   logic [1:0]  clr_idx, clr_idx_n;
   logic [4*BCD_DIGITS-1:0] bcd_reg, bcd_reg_n;
   logic has_oper, has_oper_n, has_res, has_res_n, neg, neg_n, started, started_n;
   logic [7:0] data_lcd_n;
   logic send_n, start_n, error_n;
   logic [WIDTH+3:0]   tgt_next;
   logic [2*WIDTH-1:0] sum_w, prod_w;

   assign tgt      = has_oper ? op_b : op_a;
   assign tgt_cnt  = has_oper ? b_cnt : a_cnt;
   assign tgt_next = {1'b0, tgt, 3'b000} + {3'b000, tgt, 1'b0} + {{WIDTH{1'b0}}, key};
   assign sum_w    = {{WIDTH{1'b0}}, op_a} + {{WIDTH{1'b0}}, op_b};
   assign prod_w   = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
   assign busy     = (state != IDLE);

   // LCD handshake: data_lcd is held from LCD_TX entry; once lcd_ready is seen high the
   // character is strobed with send_lcd for one cycle, and lcd_ready is not looked at again
   // until the caller issues the next character.
   always_comb begin
      state_n = state;  ret_n = ret;  key_n = key;  oper_n = oper;
      op_a_n = op_a;  op_b_n = op_b;  a_cnt_n = a_cnt;  b_cnt_n = b_cnt;
      has_oper_n = has_oper;  has_res_n = has_res;  neg_n = neg;  started_n = started;
      res_mag_n = res_mag;  bcd_reg_n = bcd_reg;  dig_cnt_n = dig_cnt;  clr_idx_n = clr_idx;
      data_lcd_n = data_lcd;  send_n = 1'b0;  to_bcd_n = data_to_bcd;  start_n = 1'b0;
      error_n = error;
      key_low = 4'd0;
      for (int i = 15; i >= 0; i--) if (keys[i]) key_low = 4'(i);
      cur_dig = 4'd0;
      for (int i = 0; i < BCD_DIGITS; i++) if (DW'(i + 1) == dig_cnt) cur_dig = bcd_reg[4*i +: 4];

      case (state)
         IDLE: if (keys != 16'd0 && keys_prev == 16'd0) begin
            key_n = key_low;
            state_n = WAIT_REL;
         end
         WAIT_REL: if (keys == 16'd0) begin
            if (error && key != 4'd12)  state_n = IDLE;
            else if (key <= 4'd9)       state_n = DIGIT;
            else if (key == 4'd12) begin state_n = CLR_SEQ; clr_idx_n = 2'd0; end
            else if (key == 4'd14)      state_n = EQ_ECHO;
            else                        state_n = OPER;
         end
         DIGIT: begin
            if (has_res) begin
               // a fresh digit after a result starts a new calculation
               op_a_n = {{(WIDTH-4){1'b0}}, key};  a_cnt_n = CW'(1);
               op_b_n = '0;  b_cnt_n = '0;  has_oper_n = 1'b0;  has_res_n = 1'b0;
               data_lcd_n = 8'h30 | {4'h0, key};  ret_n = IDLE;  state_n = LCD_TX;
            end else if (tgt_cnt == CW'(DIGITS) || tgt_next > {4'b0000, {WIDTH{1'b1}}}) begin
               state_n = IDLE;
            end else begin
               if (has_oper) begin op_b_n = tgt_next[WIDTH-1:0]; b_cnt_n = b_cnt + CW'(1); end
               else          begin op_a_n = tgt_next[WIDTH-1:0]; a_cnt_n = a_cnt + CW'(1); end
               data_lcd_n = 8'h30 | {4'h0, key};  ret_n = IDLE;  state_n = LCD_TX;
            end
         end
         OPER: begin
            if (has_oper && b_cnt != '0) begin
               state_n = IDLE;
            end else begin
               oper_n = key;  has_oper_n = 1'b1;  has_res_n = 1'b0;
               case (key)
                  4'd10:   data_lcd_n = 8'h2B;
                  4'd11:   data_lcd_n = 8'h2D;
                  4'd13:   data_lcd_n = 8'h2A;
                  default: data_lcd_n = 8'h2F;
               endcase
               ret_n = IDLE;  state_n = LCD_TX;
            end
         end
         EQ_ECHO: begin
            data_lcd_n = 8'h3D;  ret_n = CALC;  state_n = LCD_TX;
         end
         CALC: begin
            neg_n = 1'b0;
            state_n = BCD_START;
            if (!has_oper) res_mag_n = op_a;
            else case (oper)
               4'd10: if (sum_w > MAXV) error_n = 1'b1; else res_mag_n = sum_w[WIDTH-1:0];
               4'd11: if (op_a < op_b) begin neg_n = 1'b1; res_mag_n = op_b - op_a; end
                      else res_mag_n = op_a - op_b;
               4'd13: if (prod_w > MAXV) error_n = 1'b1; else res_mag_n = prod_w[WIDTH-1:0];
               default: if (op_b == '0) error_n = 1'b1; else res_mag_n = op_a / op_b;
            endcase
            if (error_n) begin
               has_res_n = 1'b0;  data_lcd_n = 8'h45;  ret_n = IDLE;  state_n = LCD_TX;
            end
         end
         BCD_START: begin
            to_bcd_n = res_mag;  start_n = 1'b1;  state_n = BCD_WAIT;
         end
         BCD_WAIT: if (bcd_done) begin
            bcd_reg_n = data_bcd;  state_n = SIGN;
         end
         SIGN: begin
            dig_cnt_n = DW'(BCD_DIGITS);  started_n = 1'b0;
            if (neg) begin data_lcd_n = 8'h2D; ret_n = OUT_DIG; state_n = LCD_TX; end
            else state_n = OUT_DIG;
         end
         OUT_DIG: begin
            if (dig_cnt == '0) begin
               op_a_n = res_mag;  op_b_n = '0;  a_cnt_n = '0;  b_cnt_n = '0;
               has_oper_n = 1'b0;  has_res_n = 1'b1;  state_n = IDLE;
            end else begin
               dig_cnt_n = dig_cnt - DW'(1);
               // leading zeros are dropped, but the units digit always goes out
               if (cur_dig != 4'd0 || started || dig_cnt == DW'(1)) begin
                  started_n = 1'b1;  data_lcd_n = 8'h30 | {4'h0, cur_dig};
                  ret_n = OUT_DIG;  state_n = LCD_TX;
               end
            end
         end
         CLR_SEQ: begin
            clr_idx_n = clr_idx + 2'd1;  ret_n = CLR_SEQ;  state_n = LCD_TX;
            case (clr_idx)
               2'd0: data_lcd_n = 8'h1B;
               2'd1: data_lcd_n = 8'h5B;
               2'd2: data_lcd_n = 8'h6A;
               default: begin
                  op_a_n = '0;  op_b_n = '0;  a_cnt_n = '0;  b_cnt_n = '0;  oper_n = 4'd0;
                  has_oper_n = 1'b0;  has_res_n = 1'b0;  neg_n = 1'b0;  error_n = 1'b0;
                  clr_idx_n = 2'd0;  state_n = IDLE;
               end
            endcase
         end
         LCD_TX: if (lcd_ready) begin
            send_n = 1'b1;  state_n = LCD_GAP;
         end
         LCD_GAP: state_n = ret;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      keys_prev <= keys;
      if (res) begin
         state <= IDLE;  ret <= IDLE;  key <= 4'd0;  oper <= 4'd0;
         op_a <= '0;  op_b <= '0;  a_cnt <= '0;  b_cnt <= '0;
         has_oper <= 1'b0;  has_res <= 1'b0;  neg <= 1'b0;  started <= 1'b0;
         res_mag <= '0;  bcd_reg <= '0;  dig_cnt <= '0;  clr_idx <= 2'd0;
         data_lcd <= 8'h00;  send_lcd <= 1'b0;  data_to_bcd <= '0;  start_bcd <= 1'b0;
         error <= 1'b0;
      end else begin
         state <= state_n;  ret <= ret_n;  key <= key_n;  oper <= oper_n;
         op_a <= op_a_n;  op_b <= op_b_n;  a_cnt <= a_cnt_n;  b_cnt <= b_cnt_n;
         has_oper <= has_oper_n;  has_res <= has_res_n;  neg <= neg_n;  started <= started_n;
         res_mag <= res_mag_n;  bcd_reg <= bcd_reg_n;  dig_cnt <= dig_cnt_n;  clr_idx <= clr_idx_n;
         data_lcd <= data_lcd_n;  send_lcd <= send_n;  data_to_bcd <= to_bcd_n;  start_bcd <= start_n;
         error <= error_n;
      end
   end

endmodule

// File: tb/tb_kalkulator_param.sv
// Bench for kalkulator_param: acts as LCD writer and BCD converter, predicts every LCD byte
// and conversion request from a decimal-arithmetic model of the calculator.
module tb_kalkulator_param;

   localparam int WIDTH = 16;
   localparam int DIGITS = 4;
   localparam int BCDD = 5;
   localparam longint MAXV = 65535;

   logic clk, res, lcd_ready, send_lcd, start_bcd, bcd_done, error, busy;
   logic [15:0] keys;
   logic [7:0] data_lcd;
   logic [WIDTH-1:0] data_to_bcd;
   logic [4*BCDD-1:0] data_bcd;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [WIDTH-1:0] bcd_exp_q[$];
   logic [WIDTH-1:0] last_bcd;
   string got, esc;
   bit stall, bcd_mute, seen_start, prev_send;

   longint m_a, m_b;
   int m_ad, m_bd, m_op;
   bit m_has_res, m_err;

   kalkulator_param #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BCD_DIGITS(BCDD)) dut (
      .clk(clk), .res(res), .keys(keys), .lcd_ready(lcd_ready), .data_lcd(data_lcd),
      .send_lcd(send_lcd), .data_to_bcd(data_to_bcd), .start_bcd(start_bcd),
      .bcd_done(bcd_done), .data_bcd(data_bcd), .error(error), .busy(busy));

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
      end
   endtask

   function automatic logic [4*BCDD-1:0] to_bcd(input logic [WIDTH-1:0] v);
      logic [4*BCDD-1:0] r;
      int n;
      n = int'(v);
      r = '0;
      for (int i = 0; i < BCDD; i++) begin
         r[4*i +: 4] = 4'(n % 10);
         n = n / 10;
      end
      return r;
   endfunction

   // behavioural calculator model
   task automatic model_reset();
      m_a = 0; m_b = 0; m_ad = 0; m_bd = 0; m_op = -1; m_has_res = 0; m_err = 0;
   endtask

   task automatic model_key(input int k);
      longint r;
      bit ng, bad;
      string s;
      if (m_err && k != 12) return;
      if (k <= 9) begin
         if (m_has_res) begin
            m_a = 0; m_b = 0; m_op = -1; m_ad = 0; m_bd = 0; m_has_res = 0;
         end
         if (m_op < 0) begin
            if (m_ad < DIGITS && m_a * 10 + k <= MAXV) begin
               m_a = m_a * 10 + k; m_ad++; exp_q.push_back(8'(48 + k));
            end
         end else if (m_bd < DIGITS && m_b * 10 + k <= MAXV) begin
            m_b = m_b * 10 + k; m_bd++; exp_q.push_back(8'(48 + k));
         end
      end else if (k == 12) begin
         exp_q.push_back(8'h1B); exp_q.push_back(8'h5B); exp_q.push_back(8'h6A);
         model_reset();
      end else if (k == 14) begin
         exp_q.push_back("=");
         ng = 0; bad = 0; r = m_a;
         case (m_op)
            10: begin r = m_a + m_b; bad = (r > MAXV); end
            11: begin if (m_a < m_b) begin ng = 1; r = m_b - m_a; end else r = m_a - m_b; end
            13: begin r = m_a * m_b; bad = (r > MAXV); end
            15: begin if (m_b == 0) bad = 1; else r = m_a / m_b; end
            default: r = m_a;
         endcase
         if (bad) begin
            exp_q.push_back("E"); m_err = 1; m_has_res = 0;
         end else begin
            if (ng) exp_q.push_back("-");
            s = $sformatf("%0d", r);
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
            bcd_exp_q.push_back(r[WIDTH-1:0]);
            m_a = r; m_b = 0; m_op = -1; m_ad = 0; m_bd = 0; m_has_res = 1;
         end
      end else if (!(m_op >= 0 && m_bd > 0)) begin
         m_has_res = 0; m_op = k;
         case (k)
            10: exp_q.push_back("+");
            11: exp_q.push_back("-");
            13: exp_q.push_back("*");
            default: exp_q.push_back("/");
         endcase
      end
   endtask

   // LCD writer: random readiness, fully stalled on request
   initial begin
      lcd_ready = 1'b0;
      forever begin
         @(negedge clk);
         lcd_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // scoreboard for LCD bytes
   always @(negedge clk) begin
      if (!res && send_lcd) begin
         got = {got, $sformatf("%c", data_lcd)};
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL lcd_extra: got %0d expected no byte", data_lcd);
         end else begin
            chk("lcd_byte", data_lcd, exp_q.pop_front());
         end
         chk("send_width", prev_send, 0);
      end
      prev_send = send_lcd;
   end

   // BCD converter with random latency
   initial begin : bcd_conv
      logic [WIDTH-1:0] be;
      logic [31:0] junk;
      int dly;
      bcd_done = 1'b0;
      data_bcd = '0;
      forever begin
         @(negedge clk);
         if (!res && start_bcd) begin
            seen_start = 1;
            last_bcd = data_to_bcd;
            if (bcd_exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL bcd_extra: got %0d expected no conversion", data_to_bcd);
               be = data_to_bcd;
            end else begin
               be = bcd_exp_q.pop_front();
               chk("bcd_value", data_to_bcd, be);
            end
            if (!bcd_mute) begin
               dly = $urandom_range(0, 4);
               repeat (dly) begin
                  @(negedge clk);
                  chk("bcd_hold", data_to_bcd, be);
                  chk("start_pulse", start_bcd, 0);
               end
               data_bcd = to_bcd(be);
               bcd_done = 1'b1;
               @(negedge clk);
               bcd_done = 1'b0;
               junk = $urandom;
               data_bcd = junk[4*BCDD-1:0];
            end
         end
      end
   end

   // driver tasks
   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 4000) begin
         checks++; errors++;
         $display("FAIL idle_timeout: busy got 1 expected 0");
      end
   endtask

   task automatic press(input logic [15:0] mask, input int hold);
      int k;
      wait_idle();
      @(negedge clk);
      keys = mask;
      repeat (hold) @(negedge clk);
      keys = 16'h0000;
      k = 0;
      for (int i = 15; i >= 0; i--) if (mask[i]) k = i;
      model_key(k);
      repeat (2) @(negedge clk);
      wait_idle();
      chk("error_flag", error, m_err);
   endtask

   function automatic int key_of(input byte c);
      case (c)
         "+": return 10;
         "-": return 11;
         "C": return 12;
         "*": return 13;
         "=": return 14;
         "/": return 15;
         default: return int'(c) - 48;
      endcase
   endfunction

   task automatic run_seq(input string s, input string expect_s, input string name);
      logic [15:0] m;
      got = "";
      for (int i = 0; i < s.len(); i++) begin
         m = '0;
         m[key_of(s[i])] = 1'b1;
         press(m, $urandom_range(1, 3));
      end
      chk_str(name, got, expect_s);
      chk("lcd_pending", exp_q.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_data_lcd"}, data_lcd, 0);
      chk({tag, "_send_lcd"}, send_lcd, 0);
      chk({tag, "_data_to_bcd"}, data_to_bcd, 0);
      chk({tag, "_start_bcd"}, start_bcd, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin : main
      int n, k, r;
      int ops[4];
      logic [15:0] m;
      ops = '{10, 11, 13, 15};
      esc = $sformatf("%c%c%c", 8'h1B, 8'h5B, 8'h6A);
      res = 1'b1; keys = 16'h0000; stall = 0; bcd_mute = 0; seen_start = 0; got = "";
      model_reset();
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      res = 1'b0;

      run_seq("12+7=", "12+7=19", "add");
      chk("add_bcd_in", last_bcd, 19);
      run_seq("*2=", "*2=38", "chain_mul");
      run_seq("4+1=", "4+1=5", "new_after_result");
      run_seq("C", esc, "clear");
      run_seq("5-9=", "5-9=-4", "sub_neg");
      chk("sub_bcd_in", last_bcd, 4);
      run_seq("C", esc, "clear");
      run_seq("7/0=", "7/0=E", "div0");
      chk("div0_error", error, 1);
      run_seq("3", "", "locked_digit");
      run_seq("C", esc, "clear_error");
      chk("clear_error_flag", error, 0);
      run_seq("12345", "1234", "digit_limit");
      run_seq("C", esc, "clear");
      run_seq("9999*9999=", "9999*9999=E", "mul_ovf");
      run_seq("C", esc, "clear");
      run_seq("9999*6=", "9999*6=59994", "mul_big");
      run_seq("+5541=", "+5541=65535", "add_max");
      run_seq("+1=", "+1=E", "add_ovf");
      run_seq("C", esc, "clear");
      run_seq("0+0=", "0+0=0", "zero");
      run_seq("=", "=0", "eq_repeat");
      run_seq("8-+3=", "8-+3=11", "op_replace");
      run_seq("1000/7=", "1000/7=142", "div");
      run_seq("+=", "+=142", "chain_no_b");
      run_seq("C", esc, "clear");

      // held key echoes once
      got = "";
      press(16'h0100, 50);
      chk_str("hold_single", got, "8");

      // LCD stalled mid-echo
      stall = 1;
      repeat (3) @(negedge clk);
      model_key(5);
      keys = 16'h0020;
      @(negedge clk);
      keys = 16'h0000;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         chk("stall_send", send_lcd, 0);
         chk("stall_data", data_lcd, 8'h35);
         @(negedge clk);
      end
      stall = 0;
      wait_idle();
      chk("stall_pending", exp_q.size(), 0);

      // reset while waiting for the converter
      run_seq("C", esc, "clear");
      run_seq("1+2", "1+2", "pre_reset");
      bcd_mute = 1; seen_start = 0;
      exp_q.push_back("=");
      bcd_exp_q.push_back(16'd3);
      keys = 16'h4000;
      @(negedge clk);
      keys = 16'h0000;
      n = 0;
      while (!seen_start && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reach_bcd_wait", seen_start, 1);
      repeat (3) @(negedge clk);
      chk("bcd_wait_busy", busy, 1);
      res = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midreset");
      res = 1'b0;
      model_reset();
      bcd_mute = 0;
      chk_str("pre_reset_echo", got, "1+2=");
      chk("midreset_pending", exp_q.size(), 0);
      run_seq("6*7=", "6*7=42", "after_reset");

      // random key stream
      for (int it = 0; it < 250; it++) begin
         r = $urandom_range(0, 99);
         if (r < 55)      k = $urandom_range(0, 9);
         else if (r < 75) k = ops[$urandom_range(0, 3)];
         else if (r < 90) k = 14;
         else if (r < 95) k = 12;
         else             k = $urandom_range(0, 9);
         m = '0;
         m[k] = 1'b1;
         if ($urandom_range(0, 9) == 0) m[$urandom_range(0, 15)] = 1'b1;
         press(m, $urandom_range(1, 4));
      end
      chk("random_pending", exp_q.size(), 0);
      chk("random_bcd_pending", bcd_exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
